// File: rtl/ram_arb_defs.sv
// Shared constants for the two-port RAM arbiter: default geometry, port IDs
// and the layout of the read-return tag.
package ram_arb_defs;

   localparam int ADDR_W_DEF     = 6;
   localparam int DATA_W_DEF     = 8;
   localparam int RD_LATENCY_DEF = 1;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   // Read tag = {valid, port}
   localparam int TAG_W        = 2;
   localparam int TAG_VLD_BIT  = 1;
   localparam int TAG_PORT_BIT = 0;

   function automatic logic [TAG_W-1:0] make_tag(input logic vld, input logic port);
      return {vld, port};
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a one-bit priority pointer; the pointer
// moves to the non-winning port on every accepted cycle.
module rr_arb2
   import ram_arb_defs::*;
(
   input  logic       clock,
   input  logic       resetn,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] gnt
);

   logic ptr_q;
   logic ptr_d;

   always_comb begin
      gnt = 2'b00;
      if (!resetn) begin
         gnt = 2'b00;
      end else begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (ptr_q == PORT0) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
   end

   // The winner yields priority to the other port
   always_comb begin
      ptr_d = ptr_q;
      if (accept) begin
         ptr_d = gnt[1] ? PORT0 : PORT1;
      end else begin
         ptr_d = ptr_q;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         ptr_q <= PORT0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/ram_arbiter2.sv
// Arbiter/sequencer between two clients and a single-port synchronous RAM:
// registered RAM controls, read-tag pipeline and per-port read-data return.
module ram_arbiter2
   import ram_arb_defs::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int RD_LATENCY = RD_LATENCY_DEF
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              rvalid0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_wren,
   input  logic [DATA_W-1:0] ram_q
);

   logic [1:0]        gnt_s;
   logic              accept_s;
   logic              sel_s;
   logic              sel_we_s;
   logic [ADDR_W-1:0] sel_addr_s;
   logic [DATA_W-1:0] sel_wdata_s;

   logic [ADDR_W-1:0] ram_address_q, ram_address_d;
   logic [DATA_W-1:0] ram_data_q, ram_data_d;
   logic              ram_wren_q, ram_wren_d;

   logic [RD_LATENCY:0][TAG_W-1:0] tag_q, tag_d;
   logic [TAG_W-1:0]               tag_out_s;

   logic              rvalid0_q, rvalid0_d;
   logic              rvalid1_q, rvalid1_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;

   rr_arb2 u_arb (
      .clock  (clock),
      .resetn (resetn),
      .req    ({req1, req0}),
      .accept (accept_s),
      .gnt    (gnt_s)
   );

   assign gnt0     = gnt_s[0];
   assign gnt1     = gnt_s[1];
   assign accept_s = gnt_s[0] | gnt_s[1];
   assign sel_s    = gnt_s[1] ? PORT1 : PORT0;

   always_comb begin
      sel_we_s    = we0;
      sel_addr_s  = addr0;
      sel_wdata_s = wdata0;
      if (sel_s == PORT1) begin
         sel_we_s    = we1;
         sel_addr_s  = addr1;
         sel_wdata_s = wdata1;
      end else begin
         sel_we_s    = we0;
         sel_addr_s  = addr0;
         sel_wdata_s = wdata0;
      end
   end

   // Address and data hold when idle; wren is a one-cycle strobe per write
   always_comb begin
      ram_address_d = ram_address_q;
      ram_data_d    = ram_data_q;
      ram_wren_d    = 1'b0;
      if (accept_s) begin
         ram_address_d = sel_addr_s;
         ram_data_d    = sel_wdata_s;
         ram_wren_d    = sel_we_s;
      end else begin
         ram_wren_d    = 1'b0;
      end
   end

   always_comb begin
      tag_d    = tag_q;
      tag_d[0] = make_tag(accept_s & ~sel_we_s, sel_s);
      for (int i = 1; i <= RD_LATENCY; i++) begin
         tag_d[i] = tag_q[i-1];
      end
   end

   assign tag_out_s = tag_q[RD_LATENCY];

   // The oldest tag steers ram_q to its owner; the other port keeps its data
   always_comb begin
      rvalid0_d = tag_out_s[TAG_VLD_BIT] & (tag_out_s[TAG_PORT_BIT] == PORT0);
      rvalid1_d = tag_out_s[TAG_VLD_BIT] & (tag_out_s[TAG_PORT_BIT] == PORT1);
      rdata0_d  = rdata0_q;
      rdata1_d  = rdata1_q;
      if (rvalid0_d) begin
         rdata0_d = ram_q;
      end else begin
         rdata0_d = rdata0_q;
      end
      if (rvalid1_d) begin
         rdata1_d = ram_q;
      end else begin
         rdata1_d = rdata1_q;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         ram_address_q <= {ADDR_W{1'b0}};
         ram_data_q    <= {DATA_W{1'b0}};
         ram_wren_q    <= 1'b0;
         tag_q         <= {((RD_LATENCY+1)*TAG_W){1'b0}};
         rvalid0_q     <= 1'b0;
         rvalid1_q     <= 1'b0;
         rdata0_q      <= {DATA_W{1'b0}};
         rdata1_q      <= {DATA_W{1'b0}};
      end else begin
         ram_address_q <= ram_address_d;
         ram_data_q    <= ram_data_d;
         ram_wren_q    <= ram_wren_d;
         tag_q         <= tag_d;
         rvalid0_q     <= rvalid0_d;
         rvalid1_q     <= rvalid1_d;
         rdata0_q      <= rdata0_d;
         rdata1_q      <= rdata1_d;
      end
   end

   assign ram_address = ram_address_q;
   assign ram_data    = ram_data_q;
   assign ram_wren    = ram_wren_q;
   assign rvalid0     = rvalid0_q;
   assign rvalid1     = rvalid1_q;
   assign rdata0      = rdata0_q;
   assign rdata1      = rdata1_q;

endmodule

// File: tb/tb_ram_arbiter2.sv
// Scoreboard bench for ram_arbiter2 with a behavioural single-port RAM and
// a reference model of grants and read returns.
module tb_ram_arbiter2;

   localparam int AW = 6;
   localparam int DW = 8;

   logic          clock  = 1'b0;
   logic          resetn = 1'b0;
   logic          req0, we0, req1, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          gnt0, gnt1, rvalid0, rvalid1;
   logic [DW-1:0] rdata0, rdata1;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_data, ram_q;
   logic          ram_wren;

   always #5 clock = ~clock;

   ram_arbiter2 dut (
      .clock(clock), .resetn(resetn),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
      .ram_address(ram_address), .ram_data(ram_data),
      .ram_wren(ram_wren), .ram_q(ram_q)
   );

   // Single-port RAM, registered address, preloaded with addr^0xFF
   logic [DW-1:0] ram_mem [64];
   logic [AW-1:0] ram_areg;
   logic          preload = 1'b1;
   always @(posedge clock) begin
      if (preload) begin
         for (int i = 0; i < 64; i++) ram_mem[i] <= 8'(i) ^ 8'hFF;
         preload <= 1'b0;
      end else if (ram_wren) begin
         ram_mem[ram_address] <= ram_data;
      end
      ram_areg <= ram_address;
   end
   assign ram_q = ram_mem[ram_areg];

   typedef struct {
      bit            port;
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   exp_t          expq[$];
   int            total = 0;
   int            bad   = 0;
   int            cyc   = 0;
   logic [DW-1:0] ref_mem [64];
   bit            last_port;
   bit            pr [2];
   bit            pw [2];
   logic [AW-1:0] pa [2];
   logic [DW-1:0] pd [2];

   always @(posedge clock) cyc <= cyc + 1;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
      end
   endfunction

   // Monitor: every rvalid must match the oldest outstanding read
   always @(negedge clock) begin
      exp_t e;
      if (rvalid0 || rvalid1) begin
         if (expq.size() == 0) begin
            chk("unexpected_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
         end else begin
            e = expq.pop_front();
            chk("rvalid_port", 32'({rvalid1, rvalid0}), e.port ? 32'd2 : 32'd1);
            chk("rdata", 32'(e.port ? rdata1 : rdata0), 32'(e.data));
            chk("latency", 32'(cyc), 32'(e.due));
         end
      end else if (expq.size() != 0 && expq[0].due <= cyc) begin
         chk("missing_rvalid", 32'd0, 32'd1);
         void'(expq.pop_front());
      end
   end

   task automatic set(input int p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      pr[p] = 1'b1; pw[p] = w; pa[p] = a; pd[p] = d;
   endtask

   function automatic void model_accept(input int p);
      exp_t e;
      if (pw[p]) begin
         ref_mem[pa[p]] = pd[p];
      end else begin
         e.port = 1'(p);
         e.data = ref_mem[pa[p]];
         e.due  = cyc + 3;
         expq.push_back(e);
      end
      last_port = 1'(p);
      pr[p]     = 1'b0;
   endfunction

   // One clock: drive pending requests, check grants, update the model
   task automatic tick();
      bit eg0, eg1;
      req0 = pr[0]; we0 = pw[0]; addr0 = pa[0]; wdata0 = pd[0];
      req1 = pr[1]; we1 = pw[1]; addr1 = pa[1]; wdata1 = pd[1];
      @(negedge clock);
      eg0 = pr[0] && (!pr[1] || last_port == 1'b1);
      eg1 = pr[1] && (!pr[0] || last_port == 1'b0);
      chk("gnt0", 32'(gnt0), 32'(eg0));
      chk("gnt1", 32'(gnt1), 32'(eg1));
      if (eg0) model_accept(0);
      if (eg1) model_accept(1);
      @(posedge clock);
      #1;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((pr[0] || pr[1]) && n < budget) begin
         tick();
         n++;
      end
      chk("drain_timeout", 32'({pr[1], pr[0]}), 32'd0);
   endtask

   task automatic wait_empty(input int budget);
      int n = 0;
      while (expq.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      chk("response_timeout", 32'(expq.size()), 32'd0);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
      expq.delete();
      pr[0] = 1'b0; pr[1] = 1'b0;
      last_port = 1'b1;
      #1;
      chk("rst_gnt0", 32'(gnt0), 32'd0);
      chk("rst_gnt1", 32'(gnt1), 32'd0);
      chk("rst_wren", 32'(ram_wren), 32'd0);
      chk("rst_addr", 32'(ram_address), 32'd0);
      chk("rst_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
      @(negedge clock);
      @(negedge clock);
      resetn = 1'b1;
      req0 = 1'b0; req1 = 1'b0;
      @(posedge clock);
      #1;
   endtask

   initial begin
      int k0, k1;
      for (int i = 0; i < 64; i++) ref_mem[i] = 8'(i) ^ 8'hFF;
      req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
      req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
      last_port = 1'b1;
      @(posedge clock);
      #1;

      // 1: reset with both requesting, then port 0 wins first
      do_reset();
      set(0, 1'b0, 6'h00, 8'h00);
      set(1, 1'b0, 6'h01, 8'h00);
      tick();
      drain(4);
      wait_empty(8);

      // 2: port 0 alone, write then read back
      set(0, 1'b1, 6'h05, 8'hA5);
      tick();
      chk("wr_wren", 32'(ram_wren), 32'd1);
      chk("wr_addr", 32'(ram_address), 32'h05);
      chk("wr_data", 32'(ram_data), 32'hA5);
      set(0, 1'b0, 6'h05, 8'h00);
      tick();
      chk("rd_wren", 32'(ram_wren), 32'd0);
      chk("rd_addr", 32'(ram_address), 32'h05);
      wait_empty(8);

      // 3: simultaneous writes then simultaneous reads from a fresh pointer
      do_reset();
      set(0, 1'b1, 6'h10, 8'h11);
      set(1, 1'b1, 6'h11, 8'h22);
      drain(4);
      set(0, 1'b0, 6'h10, 8'h00);
      set(1, 1'b0, 6'h11, 8'h00);
      drain(4);
      wait_empty(8);

      // 4: port 1 streams reads 0x00..0x07
      for (int i = 0; i < 8; i++) begin
         set(1, 1'b0, 6'(i), 8'h00);
         tick();
      end
      wait_empty(8);

      // 5: sustained contention
      k0 = 0; k1 = 0;
      repeat (8) begin
         if (!pr[0]) begin set(0, 1'b0, 6'h20 + 6'(k0), 8'h00); k0++; end
         if (!pr[1]) begin set(1, 1'b0, 6'h30 + 6'(k1), 8'h00); k1++; end
         tick();
      end
      drain(4);
      wait_empty(8);

      // Random mixed traffic
      repeat (400) begin
         for (int p = 0; p < 2; p++) begin
            if (!pr[p] && $urandom_range(0, 99) < 70)
               set(p, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)));
         end
         tick();
      end
      drain(4);
      wait_empty(8);

      // 6: reset right after a read is accepted
      set(0, 1'b0, 6'h05, 8'h00);
      tick();
      do_reset();
      repeat (4) tick();
      chk("post_rst_wren", 32'(ram_wren), 32'd0);
      set(0, 1'b0, 6'h06, 8'h00);
      set(1, 1'b0, 6'h07, 8'h00);
      tick();
      drain(4);
      wait_empty(8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

endmodule
